// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI serial-clock generator for all four CPOL/CPHA modes with mode-resolved strobes
module spi_sclk_gen #(
    parameter int DIV_LEN = 16,
    parameter int CNT_LEN = 7
) (
    input  logic               wb_clk_in,
    input  logic               wb_rst_n,
    input  logic               go,
    input  logic               abort,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [DIV_LEN-1:0] divider,
    input  logic [CNT_LEN-1:0] len,
    output logic               sclk_out,
    output logic               pos_edge,
    output logic               neg_edge,
    output logic               sample_stb,
    output logic               shift_stb,
    output logic [CNT_LEN-1:0] bit_cnt,
    output logic               tip,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e               state_q, state_d;
    logic                 cpol_q, cpha_q, load;
    logic [DIV_LEN-1:0]   div_q, half_q, half_d;
    logic [CNT_LEN-1:0]   len_q, bit_q, bit_d;
    logic [CNT_LEN+1:0]   edge_q, edge_d, edge_n, two_n;
    logic                 sclk_q, sclk_d, pos_q, pos_d, neg_q, neg_d;
    logic                 samp_q, samp_d, shft_q, shft_d, tip_q, tip_d, done_q, done_d;

    // len==0 stands for 2**CNT_LEN bits, so the final edge index is 2**(CNT_LEN+1)
    assign two_n  = (len_q == '0) ? {1'b1, {(CNT_LEN+1){1'b0}}} : {1'b0, len_q, 1'b0};
    assign edge_n = edge_q + (CNT_LEN+2)'(1);

    // next-state, divider, edge and strobe decoding
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        tip_d   = tip_q;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        samp_d  = 1'b0;
        shft_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                tip_d  = 1'b0;
                if (go && !abort) begin
                    load    = 1'b1;
                    half_d  = '0;
                    edge_d  = '0;
                    bit_d   = '0;
                    tip_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    tip_d   = 1'b0;
                    sclk_d  = cpol_q;
                end else if (half_q == div_q) begin
                    half_d = '0;
                    edge_d = edge_n;
                    sclk_d = !sclk_q;
                    pos_d  = !sclk_q;
                    neg_d  = sclk_q;
                    // odd edge index = leading edge; the last trailing edge never shifts in mode cpha=0
                    samp_d = edge_n[0] ^ cpha_q;
                    shft_d = cpha_q ? edge_n[0] : (!edge_n[0] && edge_n != two_n);
                    bit_d  = samp_d ? bit_q + CNT_LEN'(1) : bit_q;
                    if (edge_n == two_n)
                        state_d = HOLD;
                end else begin
                    half_d = half_q + DIV_LEN'(1);
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    tip_d   = 1'b0;
                    sclk_d  = cpol_q;
                end else if (half_q == div_q) begin
                    half_d  = '0;
                    done_d  = 1'b1;
                    tip_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    half_d = half_q + DIV_LEN'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            half_q  <= '0;
            edge_q  <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            samp_q  <= 1'b0;
            shft_q  <= 1'b0;
            tip_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            samp_q  <= samp_d;
            shft_q  <= shft_d;
            tip_q   <= tip_d;
            done_q  <= done_d;
        end
    end

    // transfer configuration captured at go so mid-transfer changes are ignored
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            div_q  <= '0;
            len_q  <= '0;
        end else if (load) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            div_q  <= divider;
            len_q  <= len;
        end
    end

    assign sclk_out   = sclk_q;
    assign pos_edge   = pos_q;
    assign neg_edge   = neg_q;
    assign sample_stb = samp_q;
    assign shift_stb  = shft_q;
    assign bit_cnt    = bit_q;
    assign tip        = tip_q;
    assign done       = done_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: scoreboard bench for spi_sclk_gen, expected strobe events queued at go
module tb_spi_sclk_gen;
    logic        clk = 1'b0;
    logic        rst_n, go, abort, cpol, cpha;
    logic [15:0] divider;
    logic [6:0]  len;
    logic        sclk_out, pos_edge, neg_edge, sample_stb, shift_stb, tip, done;
    logic [6:0]  bit_cnt;

    typedef struct {
        int         cyc;
        logic [4:0] stb;
        logic [6:0] bc;
        logic       sclk;
        logic       tip;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  cyc = 0;
    int  t0 = 0;
    int  rel;
    int  checks = 0;
    int  passes = 0;

    spi_sclk_gen dut (
        .wb_clk_in(clk), .wb_rst_n(rst_n), .go(go), .abort(abort), .cpol(cpol), .cpha(cpha),
        .divider(divider), .len(len), .sclk_out(sclk_out), .pos_edge(pos_edge),
        .neg_edge(neg_edge), .sample_stb(sample_stb), .shift_stb(shift_stb),
        .bit_cnt(bit_cnt), .tip(tip), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: each strobe/done cycle pops one expected event {cycle,strobes,bit_cnt,sclk,tip}
    always @(negedge clk) begin
        if (rst_n && (pos_edge | neg_edge | sample_stb | shift_stb | done)) begin
            rel = cyc - t0;
            if (q.size() == 0) begin
                check("unexpected_event", {rel[15:0], pos_edge, neg_edge, sample_stb, shift_stb, done, bit_cnt, sclk_out, tip}, 32'h0);
            end else begin
                e = q.pop_front();
                check("event", {rel[15:0], pos_edge, neg_edge, sample_stb, shift_stb, done, bit_cnt, sclk_out, tip},
                      {e.cyc[15:0], e.stb, e.bc, e.sclk, e.tip});
            end
        end
    end

    task automatic push(input int c, input logic [4:0] s, input logic [6:0] b, input logic k, input logic t);
        ev_t x;
        x.cyc = c; x.stb = s; x.bc = b; x.sclk = k; x.tip = t;
        q.push_back(x);
    endtask

    // expected events: edge k at k*(div+1); abort_at>0 drops edges at or after that cycle and done
    task automatic gen(input logic p, input logic h, input int dv, input int ln, input int abort_at);
        int         n = (ln == 0) ? 128 : ln;
        int         d = dv + 1;
        logic       s = p;
        logic [6:0] bc = 0;
        logic       lead, smp, shf;
        for (int k = 1; k <= 2 * n; k++) begin
            if (abort_at > 0 && k * d >= abort_at) return;
            s    = !s;
            lead = (k % 2) == 1;
            smp  = h ? !lead : lead;
            shf  = h ? lead : (!lead && k != 2 * n);
            if (smp) bc++;
            push(k * d, {s, !s, smp, shf, 1'b0}, bc, s, 1'b1);
        end
        if (abort_at == 0) push((2 * n + 1) * d, 5'b00001, bc, p, 1'b0);
    endtask

    task automatic start(input logic p, input logic h, input logic [15:0] dv, input logic [6:0] ln);
        @(negedge clk);
        cpol = p; cpha = h; divider = dv; len = ln; go = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        go = 1'b0;
    endtask

    task automatic drain(input string name);
        check(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; cpol = 1'b1; cpha = 1'b0; divider = 0; len = 0;
        // reset values, then idle level follows cpol one edge later
        repeat (2) @(negedge clk);
        check("reset_outputs", {sclk_out, pos_edge, neg_edge, sample_stb, shift_stb, bit_cnt, tip, done}, 0);
        rst_n = 1'b1;
        check("sclk_before_edge", sclk_out, 0);
        @(negedge clk);
        check("sclk_idle_cpol1", sclk_out, 1);

        // mode 0, divider 1, len 8: done at 34
        start(0, 0, 1, 8);
        gen(0, 0, 1, 8, 0);
        repeat (40) @(negedge clk);
        drain("mode0_drain");
        check("mode0_bitcnt", bit_cnt, 8);
        check("mode0_tip", tip, 0);

        // mode 3, divider 0, len 1: hand-computed events
        start(1, 1, 0, 1);
        push(1, 5'b01010, 0, 0, 1);
        push(2, 5'b10100, 1, 1, 1);
        push(3, 5'b00001, 1, 1, 0);
        repeat (6) @(negedge clk);
        drain("mode3_drain");

        // mode 1, divider 2, len 4, abort sampled at cycle 10
        start(0, 1, 2, 4);
        gen(0, 1, 2, 4, 10);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_tip", tip, 0);
        check("abort_sclk", sclk_out, 0);
        check("abort_bitcnt", bit_cnt, 1);
        check("abort_no_done", done, 0);
        repeat (20) @(negedge clk);
        drain("abort_drain");
        check("abort_idle_tip", tip, 0);

        // go and abort together in IDLE: abort wins
        @(negedge clk);
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        check("go_abort_idle_tip", tip, 0);

        // len 0 = 128 bits, bit_cnt wraps; go mid-run ignored
        start(0, 0, 0, 0);
        gen(0, 0, 0, 0, 0);
        repeat (100) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (210) @(negedge clk);
        drain("len0_drain");
        check("len0_bitcnt_wrap", bit_cnt, 0);
        check("len0_tip", tip, 0);

        // mode 2, divider 3, len 2 with config toggled mid-transfer: done at 20
        start(1, 0, 3, 2);
        gen(1, 0, 3, 2, 0);
        repeat (6) @(negedge clk);
        cpol = 1'b0; cpha = 1'b1; divider = 0; len = 5;
        repeat (15) @(negedge clk);
        check("midcfg_done", done, 1);
        check("midcfg_sclk_hold", sclk_out, 1);
        @(negedge clk);
        check("midcfg_sclk_idle", sclk_out, 0);
        drain("midcfg_drain");

        // asynchronous reset mid-transfer
        start(0, 0, 1, 8);
        gen(0, 0, 1, 8, 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {sclk_out, pos_edge, neg_edge, sample_stb, shift_stb, bit_cnt, tip, done}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("async_reset_idle", {tip, bit_cnt}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
